// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: forwarding select codes, register constants and
// the in-flight stage entry tracked by the hazard scoreboard.
package mips_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;

  localparam logic [FWD_W-1:0] FWD_RF    = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b10;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // One instruction slot in EX, MEM or WB.
  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             wr;
    logic             ld;
  } stage_entry_t;

  localparam stage_entry_t ENTRY_BUBBLE = '0;

  // True when the entry will write architectural register r ($0 never counts).
  function automatic logic entry_writes(input stage_entry_t e,
                                        input logic [REG_W-1:0] r);
    return e.v & e.wr & (e.rd == r) & (r != REG_ZERO);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding select for one EX source register: the youngest
// in-flight producer wins, otherwise the register file value is used.
module fwd_select
  import mips_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  stage_entry_t     ex_e,
  input  stage_entry_t     mem_e,
  output logic [FWD_W-1:0] sel_c
);

  // Priority search: EX (youngest) before MEM.
  always_comb begin
    sel_c = FWD_RF;
    if (entry_writes(ex_e, src)) begin
      sel_c = FWD_EXMEM;
    end else if (entry_writes(mem_e, src)) begin
      sel_c = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Control side of the ID/EX pipeline register: tracks destination registers
// in flight, raises the load-use stall, inserts bubbles and registers the EX
// operand forwarding selects alongside the instruction entering EX.
module hazard_scoreboard
  import mips_pkg::*;
#(
  parameter int unsigned S = 32,
  parameter int unsigned R = REG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [R-1:0]     id_rs,
  input  logic [R-1:0]     id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [R-1:0]     id_rd,
  input  logic             id_regwrite,
  input  logic             id_load,
  input  logic             ex_flush,
  output logic             stall_id,
  output logic             ex_valid,
  output logic [FWD_W-1:0] ex_fwd_a,
  output logic [FWD_W-1:0] ex_fwd_b,
  output logic [S-1:0]     stall_count
);

  // The WB slot is not stored: the register file writes before it reads, so
  // an instruction in WB can never create a hazard or need forwarding.
  stage_entry_t ex_q;
  stage_entry_t mem_q;

  logic             hz_c;
  logic             issue_c;
  stage_entry_t     ex_d_c;
  logic [FWD_W-1:0] sel_a_c;
  logic [FWD_W-1:0] sel_b_c;
  logic [FWD_W-1:0] fwd_a_d_c;
  logic [FWD_W-1:0] fwd_b_d_c;
  logic             cnt_sat_c;

  // Forwarding selects computed in ID against the current EX/MEM entries.
  fwd_select u_fwd_a (
    .src   (REG_W'(id_rs)),
    .ex_e  (ex_q),
    .mem_e (mem_q),
    .sel_c (sel_a_c)
  );

  fwd_select u_fwd_b (
    .src   (REG_W'(id_rt)),
    .ex_e  (ex_q),
    .mem_e (mem_q),
    .sel_c (sel_b_c)
  );

  // Load-use hazard against the load currently in EX; a flush overrides it.
  always_comb begin
    hz_c = 1'b0;
    if (id_valid && ex_q.ld) begin
      hz_c = (id_use_rs && entry_writes(ex_q, REG_W'(id_rs))) ||
             (id_use_rt && entry_writes(ex_q, REG_W'(id_rt)));
    end
  end

  assign stall_id = hz_c & ~ex_flush;

  // Next EX entry and its operand selects; bubbles never forward.
  always_comb begin
    issue_c   = id_valid & ~ex_flush & ~stall_id;
    ex_d_c    = ENTRY_BUBBLE;
    fwd_a_d_c = FWD_RF;
    fwd_b_d_c = FWD_RF;
    if (issue_c) begin
      ex_d_c.v  = 1'b1;
      ex_d_c.rd = REG_W'(id_rd);
      ex_d_c.wr = id_regwrite;
      ex_d_c.ld = id_load;
      if (id_use_rs) fwd_a_d_c = sel_a_c;
      if (id_use_rt) fwd_b_d_c = sel_b_c;
    end
  end

  assign cnt_sat_c = (stall_count == {S{1'b1}});

  // Stage shift, registered EX-side outputs and saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q        <= ENTRY_BUBBLE;
      mem_q       <= ENTRY_BUBBLE;
      ex_valid    <= 1'b0;
      ex_fwd_a    <= FWD_RF;
      ex_fwd_b    <= FWD_RF;
      stall_count <= '0;
    end else begin
      mem_q    <= ex_q;
      ex_q     <= ex_d_c;
      ex_valid <= ex_d_c.v;
      ex_fwd_a <= fwd_a_d_c;
      ex_fwd_b <= fwd_b_d_c;
      if (stall_id && !cnt_sat_c) begin
        stall_count <= stall_count + S'(1);
      end
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Backward/control side of the ID/EX pipeline register.
- Tracks destination registers of instructions in flight in EX, MEM and WB.
- Drives the ID-stage stall, bubble insertion into ID/EX, and the EX-stage operand forwarding selects.
- Sits beside the ID/EX register in the 5-stage 32-bit MIPS pipeline. Its outputs feed the IF/ID hold, the ID/EX no-op insertion and the EX operand muxes.

Parameters:
- S, 32, datapath width; only sizes stall_count.
- R, 5, register-address width (32 architectural registers, $0 hardwired zero).

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  synchronous, active-high; one clock, sampled on posedge clk.
- id_valid  input  1  ID holds a real instruction.
- id_rs  input  R  source register A of the ID instruction.
- id_rt  input  R  source register B of the ID instruction.
- id_use_rs  input  1  ID instruction reads rs.
- id_use_rt  input  1  ID instruction reads rt.
- id_rd  input  R  destination of the ID instruction.
- id_regwrite  input  1  ID instruction writes id_rd.
- id_load  input  1  ID instruction is a load (lw).
- ex_flush  input  1  branch/jump taken, resolved in EX; squash the ID instruction.
- stall_id  output  1  hold PC and IF/ID this cycle (combinational).
- ex_valid  output  1  EX slot holds a real instruction (registered).
- ex_fwd_a  output  2  EX operand A select: 00 register file, 01 EX/MEM result, 10 MEM/WB result (registered).
- ex_fwd_b  output  2  EX operand B select, same encoding (registered).
- stall_count  output  S  saturating count of stall cycles (registered).

Behaviour:
- Internal state: three stage entries, EX, MEM and WB. Each entry is {v, rd, wr, ld}. "Writes r" means v & wr & rd==r & r!=0.
- Reset (reset=1 at posedge):
  - All entry v cleared.
  - ex_valid=0, ex_fwd_a=ex_fwd_b=00, stall_count=0.
  - stall_id therefore reads 0 in the following cycle.
  - Reset mid-stall or mid-flush aborts it; no pending state survives.
- Load-use hazard (combinational): hz = id_valid & EX.ld & ((id_use_rs & EX writes id_rs) | (id_use_rt & EX writes id_rt)).
- stall_id = hz & ~ex_flush.
- Each posedge, when not in reset:
  - WB <= MEM and MEM <= EX.
  - EX <= bubble (v=0) if ex_flush | stall_id | ~id_valid. Otherwise EX <= {1, id_rd, id_regwrite, id_load}.
  - ex_valid <= the new EX.v.
- Forwarding, computed in ID and registered with the entry:
  - A: 01 if the current EX entry writes id_rs; else 10 if the current MEM entry writes id_rs; else 00.
  - B: same rule using id_rt.
  - The youngest producer wins.
  - A select is forced to 00 when id_use_rs=0 or the inserted entry is a bubble. B likewise with id_use_rt.
- WB vs ID same cycle: no action. The register file is write-before-read.
- Latency:
  - A load-use pair costs exactly one stall cycle.
  - Next cycle the load sits in MEM, so the consumer re-evaluates with no hazard and gets fwd=10 when it enters EX.
- Flush and stall in the same cycle: flush wins. stall_id=0 and a bubble enters EX.
- stall_count: +1 on each posedge where stall_id=1. It saturates at 2^S-1 and never wraps.
- Register $0 never causes a hazard or forwarding.

Decomposition:
- Shared package mips_pkg holds:
  - FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10;
  - REG_ZERO=5'd0;
  - the stage-entry struct {v, rd, wr, ld}.
- One natural sub-module: fwd_select. It is purely combinational, takes one source register and the EX/MEM entries, and returns a 2-bit select. It is instantiated twice, for A and B.

Test Plan:
- Reset: hold reset=1 two cycles with id_valid=1, id_load=1 -> stall_id=0, ex_valid=0, ex_fwd_a=ex_fwd_b=00, stall_count=0. After release, the first instruction reaches EX one cycle later.
- ALU back-to-back: add $3 (rd=3, wr=1), then sub using rs=3 -> sub in EX with ex_fwd_a=01. A third instruction using rt=3 two cycles after add -> ex_fwd_b=10. No stall.
- Load-use: lw $5, then add rs=5 -> stall_id=1 for exactly one cycle, ex_valid=0 for the bubble, then add in EX with ex_fwd_a=10, stall_count=1.
- $0 and unused operands: lw $0 then a use of rs=0 -> no stall, fwd 00. lw $7 then an instruction with id_use_rt=0, rt=7 -> no stall.
- Flush priority: lw $5 in EX, add rs=5 in ID, ex_flush=1 same cycle -> stall_id=0, bubble enters EX, stall_count unchanged.
- Saturation and reset mid-stall:
  - Force stall_count to 2^S-2, then stall two cycles -> reads 2^S-1 and holds.
  - Assert reset during a stall -> next cycle all outputs are at reset values.
